multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
// Multi-cycle control FSM for the 32-bit datapath. Takes the opcode/funct fields of the fetched
// instruction and the ALU zero flag, and sequences every datapath select/enable line one state at a time.
// Covers the ALU, load/store, branch, jump and stack (CALL/RET/PUSH/POP) instructions, plus HALT.
// Also counts retired instructions.
// PARAMETERS
// OPC_W    5   opcode width, instruct[31:27]
// ALUOP_W  4   ALU op width; funct = instruct[3:0] for R-type
// CNT_W    32  width of the retired-instruction counter
// PORTS
// clk          in   1        rising-edge clock
// rst_n        in   1        synchronous reset, active low
// opcode       in   OPC_W    instruct[31:27]; valid from the DECODE state on
// funct        in   ALUOP_W  instruct[3:0]
// zero         in   1        main ALU zero flag, sampled in EXEC
// regDst, aluSrc, memRead, memWrite, memToReg, regWrite, jump, bAndZ  out 1  datapath controls
// addrOp, writeDataOp, pcOp, aOp2  out 1  address, write-data, PC-source and SP/PC select lines
// aluOp        out  ALUOP_W  main ALU op (ADD=0, SUB=1)
// pcWrite, irWrite, spWrite, spDec  out 1  PC/IR/SP enables; spDec=1 means SP-=4
// halted, illegal   out 1  HALT reached / one-cycle unknown-opcode pulse
// instret      out  CNT_W    retired-instruction count
// BEHAVIOUR
// - States: RST, FETCH, DECODE, EXEC, MEM, WB, HALTED. Encodings live in the shared package.
// - rst_n low at any edge, in any state: state<=RST and instret<=0. An instruction in flight is abandoned.
// - In RST every output is 0. RST->FETCH unconditionally on the next edge.
// - Outputs are decoded from the state register plus the opcode/funct latched in DECODE.
//   bAndZ is the only output with a combinational input path (from zero); it is active in EXEC only.
// - Any control not listed for a state is 0.
// - FETCH: memRead, irWrite, addrOp=1, aOp2=1 (address=pc) -> DECODE.
// - DECODE: latch opcode/funct.
//   - HALT(11111) -> HALTED.
//   - Unknown opcode -> FETCH, with pcWrite=1 and illegal=1 for this one cycle; instret not incremented.
//   - Otherwise -> EXEC.
// - Per-opcode state path (total cycles from FETCH):
//   - R(00000): EXEC aluOp=funct -> WB regDst=1, regWrite, pcWrite. 4 cycles.
//   - ADDI(00001): EXEC aluSrc=1, ADD -> WB regWrite, pcWrite. 4 cycles.
//   - LD(00010): EXEC aluSrc=1, ADD -> MEM memRead -> WB memToReg, regWrite, pcWrite. 5 cycles.
//   - ST(00011): EXEC aluSrc=1, ADD -> MEM memWrite, pcWrite. 4 cycles.
//   - BZ(00100)/BNZ(00101): EXEC SUB, pcWrite; bAndZ=zero for BZ, ~zero for BNZ. 3 cycles.
//   - J(00110): EXEC jump, pcWrite. 3 cycles.
//   - CALL(00111): EXEC addrOp=1, aOp2=0, writeDataOp=1, memWrite, spWrite, spDec, jump, pcWrite. 3 cycles.
//   - RET(01000): EXEC addrOp=1, aOp2=0, memRead, spWrite -> MEM pcOp=1, pcWrite. 4 cycles.
//   - PUSH(01001): EXEC addrOp=1, aOp2=0, memWrite, spWrite, spDec, pcWrite. 3 cycles.
//   - POP(01010): EXEC addrOp=1, aOp2=0, memRead, spWrite -> WB memToReg, regWrite, pcWrite. 4 cycles.
//   - LDSP(01011)/STSP(01100): same paths as LD/ST with aOp2=0 base. 5/4 cycles.
// - pcWrite is asserted exactly once per instruction, in its last state, and that state returns to FETCH.
//   instret increments on that same edge and wraps modulo 2^CNT_W.
// - spWrite never coincides with regWrite. memRead and memWrite are never both 1.
// - HALTED: halted=1, all other controls 0; left only via rst_n.
// STRUCTURE
// - Shared package header cpu_ctrl_pkg holds the opcode constants, state encodings and ALU op codes
//   (ADD=0, SUB=1); the datapath uses the same header.
// - One sub-module, ctrl_decode: a combinational opcode classifier (is_rtype, is_mem, is_stack,
//   is_branch, legal) feeding the FSM next-state logic.
// TESTING
// - Reset: hold rst_n=0 for 3 clocks -> all outputs 0 and instret=0. Release -> FETCH on the first edge:
//   memRead=1, irWrite=1.
// - R-type funct=0101 -> exactly 4 cycles, aluOp=0101 in EXEC, regDst=1 with regWrite in WB,
//   single pcWrite pulse, instret 0->1.
// - BZ with zero=1 -> bAndZ=1 in EXEC. BNZ with zero=1 -> bAndZ=0. Both take 3 cycles.
// - CALL, then PUSH, POP, RET -> spDec=1 on CALL/PUSH and 0 on POP/RET; RET asserts pcOp=1 in MEM;
//   instret=4 after the sequence.
// - LD with rst_n dropped in MEM -> next state RST, no regWrite/pcWrite pulse, instret=0;
//   FETCH resumes one cycle after release.
// - Opcode 10110 -> illegal=1 for 1 cycle, instret unchanged. HALT -> halted=1 held for 100 cycles
//   with no memRead/pcWrite until reset.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multi-cycle CPU.
// The controller and the datapath both import this package for the opcode map,
// the FSM state encodings, the ALU op codes and the bundled control word.
package cpu_ctrl_pkg;

  localparam int OPC_W   = 5;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 32;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_BZ   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_BNZ  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_J    = 5'b00110;
  localparam logic [OPC_W-1:0] OP_CALL = 5'b00111;
  localparam logic [OPC_W-1:0] OP_RET  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_PUSH = 5'b01001;
  localparam logic [OPC_W-1:0] OP_POP  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_LDSP = 5'b01011;
  localparam logic [OPC_W-1:0] OP_STSP = 5'b01100;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;

  // One bundle for every datapath control line driven by the FSM.
  typedef struct packed {
    logic               regDst;
    logic               aluSrc;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic               regWrite;
    logic               jump;
    logic               bAndZ;
    logic               addrOp;
    logic               writeDataOp;
    logic               pcOp;
    logic               aOp2;
    logic               pcWrite;
    logic               irWrite;
    logic               spWrite;
    logic               spDec;
    logic               halted;
    logic               illegal;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle.
// master: the control FSM (takes opcode/funct/zero, drives every control line
//         and the retired-instruction count).
// slave : the datapath side (drives opcode/funct/zero, consumes the controls).
interface multicycle_control_if;
  import cpu_ctrl_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic [ALUOP_W-1:0] funct;
  logic               zero;

  logic regDst, aluSrc, memRead, memWrite, memToReg, regWrite, jump, bAndZ;
  logic addrOp, writeDataOp, pcOp, aOp2;
  logic [ALUOP_W-1:0] aluOp;
  logic pcWrite, irWrite, spWrite, spDec;
  logic halted, illegal;
  logic [CNT_W-1:0]   instret;

  modport master (
    input  opcode, funct, zero,
    output regDst, aluSrc, memRead, memWrite, memToReg, regWrite, jump, bAndZ,
           addrOp, writeDataOp, pcOp, aOp2, aluOp,
           pcWrite, irWrite, spWrite, spDec, halted, illegal, instret
  );

  modport slave (
    output opcode, funct, zero,
    input  regDst, aluSrc, memRead, memWrite, memToReg, regWrite, jump, bAndZ,
           addrOp, writeDataOp, pcOp, aOp2, aluOp,
           pcWrite, irWrite, spWrite, spDec, halted, illegal, instret
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier feeding the control FSM.
// op        : opcode to classify
// is_rtype  : register-register ALU op
// is_mem    : LD/ST/LDSP/STSP (take the MEM state)
// is_load   : LD/LDSP (MEM followed by WB)
// is_stack  : CALL/RET/PUSH/POP (address = SP)
// is_branch : BZ/BNZ
// is_halt   : HALT
// legal     : any opcode the controller knows, HALT included
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] op,
  output logic             is_rtype,
  output logic             is_mem,
  output logic             is_load,
  output logic             is_stack,
  output logic             is_branch,
  output logic             is_halt,
  output logic             legal
);
  assign is_rtype  = (op == OP_R);
  assign is_mem    = op inside {OP_LD, OP_ST, OP_LDSP, OP_STSP};
  assign is_load   = op inside {OP_LD, OP_LDSP};
  assign is_stack  = op inside {OP_CALL, OP_RET, OP_PUSH, OP_POP};
  assign is_branch = op inside {OP_BZ, OP_BNZ};
  assign is_halt   = (op == OP_HALT);
  // Opcodes are dense from R up to STSP; everything above is unused except HALT.
  assign legal     = (op <= OP_STSP) || is_halt;
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 32-bit datapath.
// clk, rst_n : rising-edge clock, synchronous active-low reset
// bus        : master side of multicycle_control_if (opcode/funct/zero in,
//              datapath controls, halted, illegal and instret out)
// Controls are a decode of the state register plus the opcode/funct latched in
// DECODE. Only bAndZ (from zero, in EXEC) and the DECODE-cycle illegal/pcWrite
// (from the live opcode, which is first valid in DECODE) see inputs directly.
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus
);
  state_t             state;
  logic [OPC_W-1:0]   op_q;
  logic [ALUOP_W-1:0] fn_q;
  logic [CNT_W-1:0]   cnt;
  ctrl_t              c;

  // In DECODE the instruction has not been latched yet, so classify the live opcode.
  logic [OPC_W-1:0] dec_op;
  logic is_rtype, is_mem, is_load, is_stack, is_branch, is_halt, legal;

  assign dec_op = (state == S_DECODE) ? bus.opcode : op_q;

  ctrl_decode u_dec (
    .op        (dec_op),
    .is_rtype  (is_rtype),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .is_stack  (is_stack),
    .is_branch (is_branch),
    .is_halt   (is_halt),
    .legal     (legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RST;
      op_q  <= '0;
      fn_q  <= '0;
      cnt   <= '0;
    end else begin
      // Every instruction's last state carries its single pcWrite; an illegal
      // opcode also pulses pcWrite to skip it but is not retired.
      if (c.pcWrite && !c.illegal) cnt <= cnt + 1'b1;
      case (state)
        S_RST:   state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.opcode;
          fn_q <= bus.funct;
          if (is_halt)     state <= S_HALTED;
          else if (!legal) state <= S_FETCH;
          else             state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_rtype || op_q == OP_ADDI || op_q == OP_POP) state <= S_WB;
          else if (is_mem || op_q == OP_RET)                  state <= S_MEM;
          else                                                state <= S_FETCH;
        end
        S_MEM:    state <= is_load ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RST;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.memRead = 1'b1;
        c.irWrite = 1'b1;
        c.addrOp  = 1'b1;
        c.aOp2    = 1'b1;   // address = pc
      end
      S_DECODE: begin
        if (!legal) begin
          c.pcWrite = 1'b1;
          c.illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_rtype) c.aluOp = fn_q;
        // LDSP/STSP differ from LD/ST only by the SP base, i.e. aOp2=0 (its default).
        if (op_q == OP_ADDI || is_mem) c.aluSrc = 1'b1;
        if (is_branch) begin
          c.aluOp   = ALU_SUB;
          c.pcWrite = 1'b1;
          c.bAndZ   = (op_q == OP_BZ) ? bus.zero : ~bus.zero;
        end
        if (op_q == OP_J) begin
          c.jump    = 1'b1;
          c.pcWrite = 1'b1;
        end
        if (is_stack) c.addrOp = 1'b1;   // aOp2 stays 0: address = SP
        case (op_q)
          OP_CALL: begin
            c.writeDataOp = 1'b1;
            c.memWrite    = 1'b1;
            c.spWrite     = 1'b1;
            c.spDec       = 1'b1;
            c.jump        = 1'b1;
            c.pcWrite     = 1'b1;
          end
          OP_PUSH: begin
            c.memWrite = 1'b1;
            c.spWrite  = 1'b1;
            c.spDec    = 1'b1;
            c.pcWrite  = 1'b1;
          end
          OP_RET, OP_POP: begin
            c.memRead = 1'b1;
            c.spWrite = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (is_load) begin
          c.memRead = 1'b1;
        end else if (op_q == OP_RET) begin
          c.pcOp    = 1'b1;   // PC <- popped return address
          c.pcWrite = 1'b1;
        end else begin
          c.memWrite = 1'b1;
          c.pcWrite  = 1'b1;
        end
      end
      S_WB: begin
        c.regWrite = 1'b1;
        c.pcWrite  = 1'b1;
        if (is_rtype)              c.regDst   = 1'b1;
        else if (op_q != OP_ADDI)  c.memToReg = 1'b1;   // LD/LDSP/POP
      end
      S_HALTED: c.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.regDst      = c.regDst;
  assign bus.aluSrc      = c.aluSrc;
  assign bus.memRead     = c.memRead;
  assign bus.memWrite    = c.memWrite;
  assign bus.memToReg    = c.memToReg;
  assign bus.regWrite    = c.regWrite;
  assign bus.jump        = c.jump;
  assign bus.bAndZ       = c.bAndZ;
  assign bus.addrOp      = c.addrOp;
  assign bus.writeDataOp = c.writeDataOp;
  assign bus.pcOp        = c.pcOp;
  assign bus.aOp2        = c.aOp2;
  assign bus.aluOp       = c.aluOp;
  assign bus.pcWrite     = c.pcWrite;
  assign bus.irWrite     = c.irWrite;
  assign bus.spWrite     = c.spWrite;
  assign bus.spDec       = c.spDec;
  assign bus.halted      = c.halted;
  assign bus.illegal     = c.illegal;
  assign bus.instret     = cnt;
endmodule
